vc_flow_arbiter: RTL and testbench

VC_FLOW_ARBITER -- requirements
Module: vc_flow_arbiter

---
 rtl/vc_flow_arbiter.sv | 163 ++++++++++++++++
 tb/tb_vc_flow_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/vc_flow_arbiter.sv
// vc_flow_arbiter: round-robin read arbiter across four virtual-channel FIFOs.
// Each VC can be paused or continued by one-cycle strobes. A per-VC watchdog
// resumes a VC that has stayed paused too long. Any FIFO-full error while
// running halts the arbiter until reset.
module vc_flow_arbiter #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 8
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       init,
    input  logic       idle,
    input  logic [3:0] pause_stb,
    input  logic [3:0] continue_stb,
    input  logic [3:0] error_full,
    input  logic [3:0] empty,
    input  logic       out_ready,
    output logic [3:0] pop,
    output logic       out_valid,
    output logic [1:0] vc_sel,
    output logic [3:0] paused,
    output logic [3:0] timeout_evt,
    output logic       halted
);

    typedef enum logic [1:0] {
        WAIT_INIT = 2'd0,
        RUN       = 2'd1,
        HALT      = 2'd2
    } state_t;

    // Final count value before auto-resume; unused when the watchdog is off.
    localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic             TO_EN   = (TIMEOUT > 0);

    state_t           state_q, state_d;
    logic [3:0]       paused_q, paused_d;
    logic [3:0]       timeout_evt_q, timeout_evt_d;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic [1:0]       last_grant_q, last_grant_d;
    logic             out_valid_q, out_valid_d;
    logic [1:0]       vc_sel_q, vc_sel_d;

    logic [3:0]       eligible_s;
    logic [1:0]       grant_idx_s;
    logic             grant_vld_s;
    logic             can_pop_s;

    // Round-robin grant: the first eligible VC after last_grant wins.
    // Pop is gated directly on error_full so it drops in the same cycle.
    always_comb begin
        eligible_s  = ~empty & ~paused_q;
        grant_idx_s = last_grant_q;
        grant_vld_s = 1'b0;
        // Scan farthest-first so the nearest eligible VC is the one that sticks.
        for (int k = 4; k >= 1; k--) begin
            if (eligible_s[last_grant_q + 2'(k)]) begin
                grant_idx_s = last_grant_q + 2'(k);
                grant_vld_s = 1'b1;
            end else begin
                grant_idx_s = grant_idx_s;
            end
        end
        can_pop_s = (state_q == RUN) && out_ready && !(|error_full) && grant_vld_s;
        if (can_pop_s) begin
            pop = 4'b0001 << grant_idx_s;
        end else begin
            pop = 4'b0000;
        end
    end

    // Next-state logic: FSM, pause flags, and watchdog counters.
    always_comb begin
        state_d       = state_q;
        paused_d      = paused_q;
        timeout_evt_d = 4'b0000;
        cnt_d         = cnt_q;
        case (state_q)
            WAIT_INIT: begin
                if (!init && idle) begin
                    state_d = RUN;
                end else begin
                    state_d = WAIT_INIT;
                end
            end
            RUN: begin
                if (|error_full) begin
                    state_d  = HALT;
                    paused_d = 4'b0000;
                    for (int i = 0; i < 4; i++) cnt_d[i] = '0;
                end else begin
                    for (int i = 0; i < 4; i++) begin
                        if (pause_stb[i]) begin
                            // A pause strobe wins over continue and over an expiring watchdog.
                            paused_d[i] = 1'b1;
                            cnt_d[i]    = '0;
                        end else if (paused_q[i] && TO_EN && (cnt_q[i] == TO_LAST)) begin
                            paused_d[i]      = 1'b0;
                            timeout_evt_d[i] = 1'b1;
                            cnt_d[i]         = '0;
                        end else if (continue_stb[i]) begin
                            paused_d[i] = 1'b0;
                            cnt_d[i]    = '0;
                        end else if (paused_q[i]) begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end else begin
                            cnt_d[i] = cnt_q[i];
                        end
                    end
                end
            end
            HALT: begin
                state_d  = HALT;
                paused_d = 4'b0000;
            end
            default: begin
                state_d  = WAIT_INIT;
                paused_d = 4'b0000;
            end
        endcase
    end

    // Grant bookkeeping and the downstream valid/index stage.
    always_comb begin
        out_valid_d = can_pop_s;
        if (can_pop_s) begin
            last_grant_d = grant_idx_s;
            vc_sel_d     = grant_idx_s;
        end else begin
            last_grant_d = last_grant_q;
            vc_sel_d     = vc_sel_q;
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q       <= WAIT_INIT;
            paused_q      <= 4'b0000;
            timeout_evt_q <= 4'b0000;
            last_grant_q  <= 2'd3;
            out_valid_q   <= 1'b0;
            vc_sel_q      <= 2'd0;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
        end else begin
            state_q       <= state_d;
            paused_q      <= paused_d;
            timeout_evt_q <= timeout_evt_d;
            last_grant_q  <= last_grant_d;
            out_valid_q   <= out_valid_d;
            vc_sel_q      <= vc_sel_d;
            for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign out_valid   = out_valid_q;
    assign vc_sel      = vc_sel_q;
    assign paused      = paused_q;
    assign timeout_evt = timeout_evt_q;
    assign halted      = (state_q == HALT);

endmodule

// File: tb/tb_vc_flow_arbiter.sv
// Directed testbench for vc_flow_arbiter (TIMEOUT=4) with hand-computed expectations.
module tb_vc_flow_arbiter;

    logic       CLK = 1'b0;
    logic       reset;
    logic       init;
    logic       idle;
    logic [3:0] pause_stb;
    logic [3:0] continue_stb;
    logic [3:0] error_full;
    logic [3:0] empty;
    logic       out_ready;
    logic [3:0] pop;
    logic       out_valid;
    logic [1:0] vc_sel;
    logic [3:0] paused;
    logic [3:0] timeout_evt;
    logic       halted;

    int n_vec = 0;
    int n_err = 0;

    vc_flow_arbiter #(.TIMEOUT(4), .CNT_W(8)) dut (
        .CLK          (CLK),
        .reset        (reset),
        .init         (init),
        .idle         (idle),
        .pause_stb    (pause_stb),
        .continue_stb (continue_stb),
        .error_full   (error_full),
        .empty        (empty),
        .out_ready    (out_ready),
        .pop          (pop),
        .out_valid    (out_valid),
        .vc_sel       (vc_sel),
        .paused       (paused),
        .timeout_evt  (timeout_evt),
        .halted       (halted)
    );

    always #5 CLK = ~CLK;

    task automatic c(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        reset = 1'b1; init = 1'b1; idle = 1'b0;
        pause_stb = 4'h0; continue_stb = 4'h0; error_full = 4'h0;
        empty = 4'h0; out_ready = 1'b1;

        // Reset values
        tick(); tick(); #1;
        c("rst_pop", 8'(pop), 8'h00);
        c("rst_ov", 8'(out_valid), 8'h00);
        c("rst_vc", 8'(vc_sel), 8'h00);
        c("rst_paused", 8'(paused), 8'h00);
        c("rst_tevt", 8'(timeout_evt), 8'h00);
        c("rst_halted", 8'(halted), 8'h00);

        // Still in WAIT_INIT while init is high
        reset = 1'b0;
        tick(); #1;
        c("winit_pop", 8'(pop), 8'h00);
        init = 1'b0; idle = 1'b1;

        // Round-robin from last_grant=3
        tick(); #1;
        c("rr0_pop", 8'(pop), 8'h01);
        c("rr0_ov", 8'(out_valid), 8'h00);
        tick(); #1;
        c("rr1_ov", 8'(out_valid), 8'h01);
        c("rr1_vc", 8'(vc_sel), 8'h00);
        c("rr1_pop", 8'(pop), 8'h02);
        tick(); #1;
        c("rr2_vc", 8'(vc_sel), 8'h01);
        c("rr2_pop", 8'(pop), 8'h04);
        tick(); #1;
        c("rr3_vc", 8'(vc_sel), 8'h02);
        c("rr3_pop", 8'(pop), 8'h08);
        tick(); #1;
        c("rr4_vc", 8'(vc_sel), 8'h03);
        c("rr4_pop", 8'(pop), 8'h01);

        // Pause VC1: strobe has no effect on this cycle's grant
        pause_stb = 4'b0010; #1;
        c("p1_same_pop", 8'(pop), 8'h01);
        tick(); pause_stb = 4'h0; #1;
        c("p1_paused", 8'(paused), 8'h02);
        c("p1_pop_a", 8'(pop), 8'h04);
        tick(); #1;
        c("p1_pop_b", 8'(pop), 8'h08);
        tick(); #1;
        c("p1_pop_c", 8'(pop), 8'h01);
        c("p1_paused_c", 8'(paused), 8'h02);
        continue_stb = 4'b0010;
        tick(); continue_stb = 4'h0; #1;
        c("c1_paused", 8'(paused), 8'h00);
        c("c1_tevt", 8'(timeout_evt), 8'h00);
        c("c1_pop", 8'(pop), 8'h02);

        // Pause and continue on VC2 in the same cycle: pause wins
        pause_stb = 4'b0100; continue_stb = 4'b0100; #1;
        c("pc_same_pop", 8'(pop), 8'h02);
        tick(); pause_stb = 4'h0; continue_stb = 4'h0; #1;
        c("pc_paused", 8'(paused), 8'h04);
        c("pc_pop_e", 8'(pop), 8'h08);
        tick(); #1;
        c("pc_pop_f", 8'(pop), 8'h01);
        continue_stb = 4'b0100;
        tick(); continue_stb = 4'h0; #1;
        c("pc_clear", 8'(paused), 8'h00);
        c("g_pop", 8'(pop), 8'h02);

        // Backpressure and all-empty: no pop, last_grant held at 0
        out_ready = 1'b0; #1;
        c("nordy_pop", 8'(pop), 8'h00);
        tick(); #1;
        c("nordy_ov", 8'(out_valid), 8'h00);
        c("nordy_vc", 8'(vc_sel), 8'h00);
        out_ready = 1'b1; empty = 4'hF; #1;
        c("empty_pop", 8'(pop), 8'h00);
        tick(); empty = 4'h0; #1;
        c("empty_ov", 8'(out_valid), 8'h00);
        c("lg_hold_pop", 8'(pop), 8'h02);

        // Watchdog: pause VC0 and never continue
        pause_stb = 4'b0001;
        tick(); pause_stb = 4'h0; #1;
        c("wd_k_ov", 8'(out_valid), 8'h01);
        c("wd_k_vc", 8'(vc_sel), 8'h01);
        c("wd_k_paused", 8'(paused), 8'h01);
        c("wd_k_pop", 8'(pop), 8'h04);
        tick(); #1;
        c("wd_l_pop", 8'(pop), 8'h08);
        tick(); #1;
        c("wd_m_pop", 8'(pop), 8'h02);
        tick(); #1;
        c("wd_n_paused", 8'(paused), 8'h01);
        c("wd_n_tevt", 8'(timeout_evt), 8'h00);
        c("wd_n_pop", 8'(pop), 8'h04);
        tick(); #1;
        c("wd_o_paused", 8'(paused), 8'h00);
        c("wd_o_tevt", 8'(timeout_evt), 8'h01);
        c("wd_o_pop", 8'(pop), 8'h08);
        tick(); #1;
        c("wd_p_tevt", 8'(timeout_evt), 8'h00);
        c("wd_p_pop", 8'(pop), 8'h01);

        // Error: pop gated immediately, HALT next cycle, pause flags cleared
        pause_stb = 4'b0100;
        tick(); pause_stb = 4'h0; #1;
        c("err_pre_paused", 8'(paused), 8'h04);
        c("err_pre_pop", 8'(pop), 8'h02);
        error_full = 4'b1000; #1;
        c("err_pop", 8'(pop), 8'h00);
        tick(); error_full = 4'h0; pause_stb = 4'hF; #1;
        c("halt_halted", 8'(halted), 8'h01);
        c("halt_paused", 8'(paused), 8'h00);
        c("halt_ov", 8'(out_valid), 8'h00);
        c("halt_vc", 8'(vc_sel), 8'h00);
        c("halt_pop", 8'(pop), 8'h00);
        tick(); pause_stb = 4'h0; #1;
        c("halt_strobe_ign", 8'(paused), 8'h00);
        c("halt_hold", 8'(halted), 8'h01);

        // Asynchronous reset out of HALT, then mid-RUN
        reset = 1'b1; #1;
        c("ar_halted", 8'(halted), 8'h00);
        c("ar_pop", 8'(pop), 8'h00);
        reset = 1'b0;
        tick(); #1;
        c("rerun_pop", 8'(pop), 8'h01);
        tick(); #1;
        c("rerun_ov", 8'(out_valid), 8'h01);
        c("rerun_pop2", 8'(pop), 8'h02);
        reset = 1'b1; #1;
        c("mid_rst_pop", 8'(pop), 8'h00);
        c("mid_rst_ov", 8'(out_valid), 8'h00);
        tick(); #1;
        c("mid_rst_ov2", 8'(out_valid), 8'h00);
        c("mid_rst_halted", 8'(halted), 8'h00);
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
